bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/done handshake.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic [3:0] BCD_BLANK   = 4'hF;
   localparam logic [3:0] BCD_NINE    = 4'h9;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Single-digit add-3 correction used before each double-dabble shift.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] d_in,
   output logic [3:0] d_out
);

   // Digits 5..9 would become 10..18 after doubling; pre-adding 3 makes the shift carry correctly.
   always_comb begin
      d_out = d_in;
      if (d_in >= ADD3_THRESH) begin
         d_out = d_in + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, feeding 7-segment digit decoders.
//
// state | meaning
// IDLE  | waiting for start; bin is captured on the accepting edge
// SHIFT | add-3 then shift one bit per cycle, BIN_W cycles
// DONE  | one-cycle done pulse; bcd/ovf were loaded on the edge that entered here
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_e             state_q, state_d;
   logic [BIN_W-1:0]   shreg_q, shreg_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_st_q, ovf_st_d;
   logic [ACC_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_shift;
   logic [BIN_W-1:0]   shreg_shift;
   logic               ovf_next;
   logic [ACC_W-1:0]   fmt;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_add3
         bcd_add3 u_add3 (
            .d_in  (acc_q[4*g +: 4]),
            .d_out (acc_adj[4*g +: 4])
         );
      end
   endgenerate

   // One double-dabble step: corrected accumulator and shift register move left together;
   // whatever leaves the top digit means the value no longer fits in DIGITS digits.
   always_comb begin
      acc_shift   = {acc_adj[ACC_W-2:0], shreg_q[BIN_W-1]};
      shreg_shift = shreg_q << 1;
      ovf_next    = ovf_st_q | acc_adj[ACC_W-1];
   end

   // Display formatting of the final step: saturate to all nines on overflow, otherwise blank leading zeros.
   always_comb begin
      logic lead;
      fmt  = acc_shift;
      lead = 1'b1;
      if (ovf_next) begin
         fmt = {DIGITS{BCD_NINE}};
      end else if (BLANK_LZ != 0) begin
         for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (fmt[4*k +: 4] == 4'h0)) begin
               fmt[4*k +: 4] = BCD_BLANK;
            end else begin
               lead = 1'b0;
            end
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_st_d = ovf_st_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SHIFT;
               shreg_d  = bin;
               acc_d    = '0;
               ovf_st_d = 1'b0;
               cnt_d    = CNT_W'(BIN_W - 1);
            end
         end
         SHIFT: begin
            acc_d    = acc_shift;
            shreg_d  = shreg_shift;
            ovf_st_d = ovf_next;
            if (cnt_q == '0) begin
               state_d = DONE;
               bcd_d   = fmt;
               ovf_d   = ovf_next;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_st_q <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_st_q <= ovf_st_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with a decimal reference model and a per-cycle output tracker.
module tb_bin2bcd_seq;

   localparam int BIN_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_bc;

   logic        start_a, busy_a, done_a, ovf_a;
   logic [7:0]  bin_a;
   logic [11:0] bcd_a;

   logic        start_b, busy_b, done_b, ovf_b;
   logic [9:0]  bin_b;
   logic [11:0] bcd_b;

   logic        start_c, busy_c, done_c, ovf_c;
   logic [7:0]  bin_c;
   logic [11:0] bcd_c;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(1)) dut_a (
      .clk(clk), .rst_n(rst_a), .start(start_a), .bin(bin_a),
      .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a));

   bin2bcd_seq #(.BIN_W(10), .DIGITS(3), .BLANK_LZ(1)) dut_b (
      .clk(clk), .rst_n(rst_bc), .start(start_b), .bin(bin_b),
      .busy(busy_b), .done(done_b), .bcd(bcd_b), .ovf(ovf_b));

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .BLANK_LZ(0)) dut_c (
      .clk(clk), .rst_n(rst_bc), .start(start_c), .bin(bin_c),
      .busy(busy_c), .done(done_c), .bcd(bcd_c), .ovf(ovf_c));

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   logic [12:0] held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal reference: {ovf, three digits}; leading digits beyond the value's length are blanked.
   function automatic logic [12:0] model(input int v, input bit blank);
      logic [11:0] r;
      int nd, p, t;
      if (v > 999) return {1'b1, 12'h999};
      nd = 1;
      t  = v;
      while (t >= 10) begin
         t = t / 10;
         nd++;
      end
      p = 1;
      for (int k = 0; k < 3; k++) begin
         if (blank && k >= nd) r[4*k +: 4] = 4'hF;
         else                  r[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return {1'b0, r};
   endfunction

   // Every cycle out of reset: outputs must equal the last finished conversion (or zero after reset).
   always @(negedge clk) begin
      if (!rst_a) begin
         exp_q.delete();
         held = '0;
      end else begin
         if (done_a) begin
            if (exp_q.size() == 0) check("spurious_done", 32'(done_a), 32'd0);
            else held = model(exp_q.pop_front(), 1'b1);
         end
         check("track_a", 32'({ovf_a, bcd_a}), 32'(held));
      end
   end

   task automatic wait_idle_a();
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (!busy_a && !done_a) ok = 1;
         else @(negedge clk);
      end
      check("idle_timeout_a", 32'(ok), 32'd1);
   endtask

   task automatic convert_a(input int v);
      int n, nb;
      bit got;
      wait_idle_a();
      bin_a   = 8'(v);
      start_a = 1'b1;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      bin_a   = 8'($urandom);
      n = 0; nb = 0; got = 0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (busy_a) nb++;
         if (done_a) begin
            got = 1;
            n   = i;
         end
      end
      check("latency_a", 32'(n), 32'(BIN_W + 1));
      check("busy_cycles_a", 32'(nb), 32'(BIN_W));
   endtask

   task automatic run_b(input int v, output logic [12:0] res);
      bit got = 0;
      for (int i = 0; i < 40 && (busy_b || done_b); i++) @(negedge clk);
      bin_b   = 10'(v);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done_b) got = 1;
      end
      check("done_timeout_b", 32'(got), 32'd1);
      res = {ovf_b, bcd_b};
   endtask

   task automatic run_c(input int v, output logic [12:0] res);
      bit got = 0;
      for (int i = 0; i < 40 && (busy_c || done_c); i++) @(negedge clk);
      bin_c   = 8'(v);
      start_c = 1'b1;
      @(posedge clk);
      #1;
      start_c = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (done_c) got = 1;
      end
      check("done_timeout_c", 32'(got), 32'd1);
      res = {ovf_c, bcd_c};
   endtask

   initial begin
      logic [12:0] r;
      int d1, d2, nd;
      rst_a = 1'b0; rst_bc = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      bin_a = '0; bin_b = '0; bin_c = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_bcd", 32'(bcd_a), 32'd0);
      check("rst_ovf", 32'(ovf_a), 32'd0);
      @(negedge clk);
      rst_a = 1'b1; rst_bc = 1'b1;

      // pin the model to hand-worked values
      check("model_255", 32'(model(255, 1)), 32'h0255);
      check("model_7", 32'(model(7, 1)), 32'h0FF7);
      check("model_0", 32'(model(0, 1)), 32'h0FF0);
      check("model_7_nb", 32'(model(7, 0)), 32'h0007);
      check("model_42", 32'(model(42, 1)), 32'h0F42);
      check("model_1000", 32'(model(1000, 1)), 32'h1999);

      convert_a(255);
      check("t1_bcd", 32'(bcd_a), 32'h255);
      check("t1_ovf", 32'(ovf_a), 32'd0);

      convert_a(7);
      check("t2_bcd7", 32'(bcd_a), 32'hFF7);
      convert_a(0);
      check("t2_bcd0", 32'(bcd_a), 32'hFF0);
      run_c(7, r);
      check("t2_noblank7", 32'(r), 32'h0007);
      run_c(100, r);
      check("t2_noblank100", 32'(r), 32'(model(100, 0)));

      run_b(1000, r);
      check("t3_ovf1000", 32'(r), 32'h1999);
      run_b(999, r);
      check("t3_999", 32'(r), 32'h0999);
      run_b(1023, r);
      check("t3_1023", 32'(r), 32'(model(1023, 1)));
      run_b(5, r);
      check("t3_5", 32'(r), 32'h0FF5);

      // start held high: only IDLE samples it, so conversions repeat every BIN_W+2 cycles
      wait_idle_a();
      bin_a   = 8'd42;
      start_a = 1'b1;
      exp_q.push_back(42);
      exp_q.push_back(42);
      d1 = 0; d2 = 0; nd = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done_a) begin
            nd++;
            if (nd == 1) d1 = i;
            else d2 = i;
         end
      end
      start_a = 1'b0;
      check("t4_num_done", 32'(nd), 32'd2);
      check("t4_first_done", 32'(d1), 32'(BIN_W + 1));
      check("t4_spacing", 32'(d2 - d1), 32'(BIN_W + 2));
      check("t4_bcd", 32'(bcd_a), 32'hF42);

      // reset during the fourth shift cycle
      wait_idle_a();
      bin_a   = 8'd200;
      start_a = 1'b1;
      exp_q.push_back(200);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_a = 1'b0;
      #1;
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_done", 32'(done_a), 32'd0);
      check("t5_bcd", 32'(bcd_a), 32'd0);
      check("t5_ovf", 32'(ovf_a), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1;
      repeat (15) @(negedge clk);
      convert_a(200);
      check("t5_bcd200", 32'(bcd_a), 32'h200);

      for (int v = 0; v < 256; v++) convert_a(v);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
